// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, mid-bit sampling FSM,
// parity/framing checks and running sum/count of clean frames.
module uart_rx_cfg #(
   parameter int unsigned cycles_per_bit = 3,
   parameter int unsigned data_bits      = 8,
   parameter int unsigned parity_mode    = 0,
   parameter int unsigned stop_bits      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_serial,
   output logic [data_bits-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_idle,
   output logic [31:0]          o_sum,
   output logic [15:0]          o_count
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   localparam logic [15:0] FULL = 16'(cycles_per_bit - 1);
   localparam logic [15:0] HALF = 16'(cycles_per_bit / 2 - 1);
   localparam logic [3:0]  LAST_DATA = 4'(data_bits - 1);
   localparam logic        LAST_STOP = 1'(stop_bits - 1);
   localparam logic        ODD = (parity_mode == 2);

   state_t               state;
   logic                 sync1, line;
   logic [15:0]          cnt;
   logic [3:0]           bit_idx;
   logic                 stop_idx;
   logic [data_bits-1:0] shreg;
   logic                 par, perr, ferr;
   logic                 frame_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         line  <= 1'b1;
      end else begin
         sync1 <= i_serial;
         line  <= sync1;
      end
   end

   // Includes the stop bit being sampled right now, so the final-stop decision is not a cycle late.
   assign frame_bad = ferr | ~line;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         stop_idx     <= 1'b0;
         shreg        <= '0;
         par          <= 1'b0;
         perr         <= 1'b0;
         ferr         <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_idle       <= 1'b1;
         o_sum        <= '0;
         o_count      <= '0;
      end else begin
         o_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!line) begin
                  state    <= START;
                  o_idle   <= 1'b0;
                  cnt      <= HALF;
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
                  par      <= 1'b0;
                  perr     <= 1'b0;
                  ferr     <= 1'b0;
               end
            end
            START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 16'd1;
               end else if (line) begin
                  state  <= IDLE;
                  o_idle <= 1'b1;
               end else begin
                  state <= DATA;
                  cnt   <= FULL;
               end
            end
            DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 16'd1;
               end else begin
                  cnt     <= FULL;
                  shreg   <= {line, shreg[data_bits-1:1]};
                  par     <= par ^ line;
                  bit_idx <= bit_idx + 4'd1;
                  if (bit_idx == LAST_DATA)
                     state <= (parity_mode != 0) ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 16'd1;
               end else begin
                  cnt   <= FULL;
                  perr  <= par ^ line ^ ODD;
                  state <= STOP;
               end
            end
            STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 16'd1;
               end else if (stop_idx == LAST_STOP) begin
                  cnt          <= FULL;
                  o_valid      <= 1'b1;
                  o_data       <= shreg;
                  o_parity_err <= perr;
                  o_frame_err  <= frame_bad;
                  if (!perr && !frame_bad) begin
                     o_sum   <= o_sum + 32'(shreg);
                     o_count <= o_count + 16'd1;
                  end
                  state  <= frame_bad ? BREAK : IDLE;
                  o_idle <= ~frame_bad;
               end else begin
                  cnt      <= FULL;
                  ferr     <= frame_bad;
                  stop_idx <= 1'b1;
               end
            end
            BREAK: begin
               if (line) begin
                  state  <= IDLE;
                  o_idle <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               o_idle <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1/3, 8E1/3, 7O2/16)
// driven by a linear step sequence with immediate-assertion checks.
module tb_uart_rx_cfg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  ser = 3'b111;

   logic [7:0]  data_a, data_b;
   logic [6:0]  data_c;
   logic        valid_a, valid_b, valid_c;
   logic        perr_a, perr_b, perr_c;
   logic        ferr_a, ferr_b, ferr_c;
   logic        idle_a, idle_b, idle_c;
   logic [31:0] sum_a, sum_b, sum_c;
   logic [15:0] count_a, count_b, count_c;

   int errors = 0;
   int checks = 0;
   int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
   int v0;

   always #5 clk = ~clk;

   uart_rx_cfg #(.cycles_per_bit(3), .data_bits(8), .parity_mode(0), .stop_bits(1)) dut_a (
      .clk(clk), .rst(rst), .i_serial(ser[0]), .o_data(data_a), .o_valid(valid_a),
      .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_idle(idle_a), .o_sum(sum_a), .o_count(count_a));

   uart_rx_cfg #(.cycles_per_bit(3), .data_bits(8), .parity_mode(1), .stop_bits(1)) dut_b (
      .clk(clk), .rst(rst), .i_serial(ser[1]), .o_data(data_b), .o_valid(valid_b),
      .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_idle(idle_b), .o_sum(sum_b), .o_count(count_b));

   uart_rx_cfg #(.cycles_per_bit(16), .data_bits(7), .parity_mode(2), .stop_bits(2)) dut_c (
      .clk(clk), .rst(rst), .i_serial(ser[2]), .o_data(data_c), .o_valid(valid_c),
      .o_parity_err(perr_c), .o_frame_err(ferr_c), .o_idle(idle_c), .o_sum(sum_c), .o_count(count_c));

   always @(negedge clk) begin
      if (valid_a) vcnt_a <= vcnt_a + 1;
      if (valid_b) vcnt_b <= vcnt_b + 1;
      if (valid_c) vcnt_c <= vcnt_c + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input int k, input logic b, input int cycles);
      ser[k] = b;
      repeat (cycles) @(negedge clk);
   endtask

   // par_force < 0 means send the correct parity bit for the mode
   task automatic send_frame(input int k, input logic [8:0] d, input int db, input int pm,
                             input int par_force, input int ns, input int cpb);
      logic p;
      p = 1'b0;
      for (int i = 0; i < db; i++) p = p ^ d[i];
      if (pm == 2) p = ~p;
      if (par_force >= 0) p = (par_force != 0);
      drive_bit(k, 1'b0, cpb);
      for (int i = 0; i < db; i++) drive_bit(k, d[i], cpb);
      if (pm != 0) drive_bit(k, p, cpb);
      for (int i = 0; i < ns; i++) drive_bit(k, 1'b1, cpb);
   endtask

   task automatic pulse_rst;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] hello [5];
      logic [7:0] fe_byte;
      hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
      fe_byte = 8'h12;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      chk("rst_data", 32'(data_a), 32'h0);
      chk("rst_valid", 32'(valid_a), 32'h0);
      chk("rst_perr", 32'(perr_a), 32'h0);
      chk("rst_ferr", 32'(ferr_a), 32'h0);
      chk("rst_idle", 32'(idle_a), 32'h1);
      chk("rst_sum", sum_a, 32'h0);
      chk("rst_count", 32'(count_a), 32'h0);

      // 8N1 single byte
      send_frame(0, 9'h055, 8, 0, -1, 1, 3);
      repeat (8) @(negedge clk);
      chk("t55_vcnt", 32'(vcnt_a), 32'd1);
      chk("t55_data", 32'(data_a), 32'h55);
      chk("t55_perr", 32'(perr_a), 32'h0);
      chk("t55_ferr", 32'(ferr_a), 32'h0);
      chk("t55_sum", sum_a, 32'h55);
      chk("t55_count", 32'(count_a), 32'd1);

      // "Hello" back-to-back, from a fresh reset
      pulse_rst();
      repeat (2) @(negedge clk);
      v0 = vcnt_a;
      for (int i = 0; i < 5; i++) send_frame(0, {1'b0, hello[i]}, 8, 0, -1, 1, 3);
      repeat (8) @(negedge clk);
      chk("hello_vcnt", 32'(vcnt_a - v0), 32'd5);
      chk("hello_sum", sum_a, 32'h1F4);
      chk("hello_count", 32'(count_a), 32'd5);
      chk("hello_data", 32'(data_a), 32'h6F);
      chk("hello_idle", 32'(idle_a), 32'h1);

      // stop bit held low for 10 bit times -> frame error and BREAK
      v0 = vcnt_a;
      drive_bit(0, 1'b0, 3);
      for (int i = 0; i < 8; i++) drive_bit(0, fe_byte[i], 3);
      drive_bit(0, 1'b0, 30);
      chk("fe_vcnt", 32'(vcnt_a - v0), 32'd1);
      chk("fe_ferr", 32'(ferr_a), 32'h1);
      chk("fe_perr", 32'(perr_a), 32'h0);
      chk("fe_data", 32'(data_a), 32'h12);
      chk("fe_sum", sum_a, 32'h1F4);
      chk("fe_count", 32'(count_a), 32'd5);
      chk("fe_break_idle", 32'(idle_a), 32'h0);
      drive_bit(0, 1'b1, 6);
      chk("fe_exit_idle", 32'(idle_a), 32'h1);
      send_frame(0, 9'h041, 8, 0, -1, 1, 3);
      repeat (8) @(negedge clk);
      chk("after_fe_vcnt", 32'(vcnt_a - v0), 32'd2);
      chk("after_fe_ferr", 32'(ferr_a), 32'h0);
      chk("after_fe_data", 32'(data_a), 32'h41);
      chk("after_fe_sum", sum_a, 32'h235);
      chk("after_fe_count", 32'(count_a), 32'd6);

      // single-cycle glitch low is a false start
      v0 = vcnt_a;
      drive_bit(0, 1'b0, 1);
      drive_bit(0, 1'b1, 12);
      chk("false_vcnt", 32'(vcnt_a - v0), 32'd0);
      chk("false_idle", 32'(idle_a), 32'h1);
      chk("false_data", 32'(data_a), 32'h41);
      chk("false_ferr", 32'(ferr_a), 32'h0);

      // 8E1: wrong then correct parity
      send_frame(1, 9'h0A5, 8, 1, 1, 1, 3);
      repeat (8) @(negedge clk);
      chk("pe_vcnt", 32'(vcnt_b), 32'd1);
      chk("pe_perr", 32'(perr_b), 32'h1);
      chk("pe_ferr", 32'(ferr_b), 32'h0);
      chk("pe_sum", sum_b, 32'h0);
      chk("pe_count", 32'(count_b), 32'd0);
      send_frame(1, 9'h0A5, 8, 1, 0, 1, 3);
      repeat (8) @(negedge clk);
      chk("pok_vcnt", 32'(vcnt_b), 32'd2);
      chk("pok_perr", 32'(perr_b), 32'h0);
      chk("pok_data", 32'(data_b), 32'hA5);
      chk("pok_sum", sum_b, 32'hA5);
      chk("pok_count", 32'(count_b), 32'd1);

      // 7O2 at 16 cycles/bit: clean frame, then reset mid-data
      send_frame(2, 9'h011, 7, 2, -1, 2, 16);
      repeat (20) @(negedge clk);
      chk("c11_vcnt", 32'(vcnt_c), 32'd1);
      chk("c11_data", 32'(data_c), 32'h11);
      chk("c11_perr", 32'(perr_c), 32'h0);
      chk("c11_count", 32'(count_c), 32'd1);
      v0 = vcnt_c;
      drive_bit(2, 1'b0, 16 + 48);
      ser[2] = 1'b1;
      pulse_rst();
      chk("mrst_data", 32'(data_c), 32'h0);
      chk("mrst_valid", 32'(valid_c), 32'h0);
      chk("mrst_perr", 32'(perr_c), 32'h0);
      chk("mrst_ferr", 32'(ferr_c), 32'h0);
      chk("mrst_idle", 32'(idle_c), 32'h1);
      chk("mrst_sum", sum_c, 32'h0);
      chk("mrst_count", 32'(count_c), 32'd0);
      repeat (200) @(negedge clk);
      chk("mrst_no_valid", 32'(vcnt_c - v0), 32'd0);
      send_frame(2, 9'h03C, 7, 2, -1, 2, 16);
      repeat (20) @(negedge clk);
      chk("c3c_vcnt", 32'(vcnt_c - v0), 32'd1);
      chk("c3c_data", 32'(data_c), 32'h3C);
      chk("c3c_perr", 32'(perr_c), 32'h0);
      chk("c3c_ferr", 32'(ferr_c), 32'h0);
      chk("c3c_sum", sum_c, 32'h3C);
      chk("c3c_count", 32'(count_c), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
